// File: rtl/avst_pkt_arbiter.sv
// Packet-locked round-robin arbiter in front of a shared adder_avst datapath.
// A tag FIFO remembers which requester owns each in-flight packet so responses return in order.
module avst_pkt_arbiter #(
    parameter int N         = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [8*N-1:0] in_data,
    input  logic [N-1:0]   in_end,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [7:0]     adder_data,
    output logic           adder_end,
    output logic           adder_valid,
    input  logic           adder_ready,
    input  logic [7:0]     rsp_data,
    input  logic           rsp_end,
    input  logic           rsp_valid,
    output logic           rsp_ready,
    output logic [7:0]     out_data,
    output logic           out_end,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic           err_orphan
);

    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = $clog2(TAG_DEPTH);

    typedef logic [TW-1:0] tag_t;
    typedef logic [AW:0]   ptr_t;
    typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_e;

    localparam ptr_t PTR_ONE = ptr_t'(1);

    state_e state_q, state_d;
    tag_t   grant_q, grant_d;
    tag_t   last_q, last_d;
    tag_t   tags_q [TAG_DEPTH];
    ptr_t   wr_ptr_q, rd_ptr_q;
    logic   err_q;

    tag_t   pick;
    logic   pick_vld;
    logic   push, pop;
    logic   empty, full;
    tag_t   head;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = tags_q[rd_ptr_q[AW-1:0]];
    assign err_orphan = err_q;

    // Ports above last win over ports at or below it; lowest index wins inside each group.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i] && (tag_t'(i) <= last_q)) begin
                pick     = tag_t'(i);
                pick_vld = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i] && (tag_t'(i) > last_q)) begin
                pick     = tag_t'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        push        = 1'b0;
        in_ready    = '0;
        adder_data  = '0;
        adder_end   = 1'b0;
        adder_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld && !full) begin
                    grant_d = pick;
                    push    = 1'b1;
                    state_d = PASS;
                end
            end
            PASS: begin
                for (int i = 0; i < N; i++) begin
                    if (grant_q == tag_t'(i)) begin
                        adder_data  = in_data[8*i +: 8];
                        adder_end   = in_end[i];
                        adder_valid = in_valid[i];
                        in_ready[i] = adder_ready;
                        if (in_valid[i] && adder_ready && in_end[i]) begin
                            last_d  = grant_q;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = '0;
        rsp_ready = 1'b0;
        out_data  = '0;
        out_end   = 1'b0;
        pop       = 1'b0;
        if (!empty) begin
            out_data = rsp_data;
            out_end  = rsp_end;
            for (int i = 0; i < N; i++) begin
                if (head == tag_t'(i)) begin
                    out_valid[i] = rsp_valid;
                    rsp_ready    = out_ready[i];
                    pop          = rsp_valid && out_ready[i] && rsp_end;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= tag_t'(N - 1);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tags_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            if (push) begin
                tags_q[wr_ptr_q[AW-1:0]] <= grant_d;
                wr_ptr_q                 <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (empty && rsp_valid) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avst_pkt_arbiter.sv
// Bench for avst_pkt_arbiter: directed corner cases plus randomized packet traffic
// against a packet-level round-robin / in-order-response model; the bench plays the adder.
module tb_avst_pkt_arbiter;

    localparam int N         = 4;
    localparam int TAG_DEPTH = 4;
    localparam int MAXB      = 32;
    localparam int RBOUND    = 4000;

    logic           clk = 1'b0;
    logic           reset;
    logic [8*N-1:0] in_data;
    logic [N-1:0]   in_end;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [7:0]     adder_data;
    logic           adder_end;
    logic           adder_valid;
    logic           adder_ready;
    logic [7:0]     rsp_data;
    logic           rsp_end;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [7:0]     out_data;
    logic           out_end;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic           err_orphan;

    avst_pkt_arbiter #(.N(N), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_end(in_end), .in_valid(in_valid), .in_ready(in_ready),
        .adder_data(adder_data), .adder_end(adder_end), .adder_valid(adder_valid),
        .adder_ready(adder_ready),
        .rsp_data(rsp_data), .rsp_end(rsp_end), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .out_data(out_data), .out_end(out_end), .out_valid(out_valid), .out_ready(out_ready),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Per-port packet streams and the in-flight response model.
    logic [7:0] beat_d [N][MAXB];
    logic       beat_e [N][MAXB];
    int         nb [N];
    int         bp [N];
    int         cur_src;
    int         last_m;
    logic [7:0] pend_d [$];
    logic       pend_e [$];
    logic [7:0] rq_d [$];
    logic       rq_e [$];
    int         rq_s [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({in_ready, adder_valid, adder_data, adder_end, rsp_ready,
                    out_valid, out_data, out_end, err_orphan});
    endfunction

    function automatic int rr_pick(input int last);
        for (int k = 1; k <= N; k++) begin
            if (bp[(last + k) % N] < nb[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit all_done();
        for (int i = 0; i < N; i++) begin
            if (bp[i] < nb[i]) return 1'b0;
        end
        return (rq_d.size() == 0) && (cur_src < 0);
    endfunction

    task automatic clear_inputs();
        in_data     = '0;
        in_end      = '0;
        in_valid    = '0;
        adder_ready = 1'b0;
        rsp_data    = '0;
        rsp_end     = 1'b0;
        rsp_valid   = 1'b0;
        out_ready   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        in_valid    = '1;
        in_data     = '1;
        in_end      = '1;
        adder_ready = 1'b1;
        rsp_valid   = 1'b1;
        rsp_data    = 8'hFF;
        rsp_end     = 1'b1;
        out_ready   = '1;
        #1 chk("reset_outs", outs_vec(), 32'h0);
        @(negedge clk);
        #1 chk("reset_hold", outs_vec(), 32'h0);
        clear_inputs();
        reset = 1'b1;
    endtask

    task automatic gen_round();
        int k, npk, len;
        for (int i = 0; i < N; i++) begin
            k   = 0;
            npk = $urandom_range(0, 4);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    beat_d[i][k] = 8'($urandom);
                    beat_e[i][k] = (b == len - 1);
                    k++;
                end
            end
            nb[i] = k;
            bp[i] = 0;
        end
        pend_d.delete(); pend_e.delete();
        rq_d.delete(); rq_e.delete(); rq_s.delete();
        cur_src = -1;
        last_m  = N - 1;
    endtask

    task automatic run_random();
        int  cyc, p, e, s;
        logic eb;
        gen_round();
        cyc = 0;
        while (!all_done() && cyc < RBOUND) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (bp[i] < nb[i]) begin
                    in_valid[i]       = 1'b1;
                    in_data[8*i +: 8] = beat_d[i][bp[i]];
                    in_end[i]         = beat_e[i][bp[i]];
                end else begin
                    in_valid[i]       = 1'b0;
                    in_data[8*i +: 8] = 8'h00;
                    in_end[i]         = 1'b0;
                end
            end
            adder_ready = ($urandom_range(0, 3) != 0);
            out_ready   = N'($urandom);
            if (rq_d.size() > 0 && $urandom_range(0, 2) != 0) begin
                rsp_valid = 1'b1;
                rsp_data  = rq_d[0];
                rsp_end   = rq_e[0];
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = 8'h00;
                rsp_end   = 1'b0;
            end
            #1;
            if (adder_valid && adder_ready) begin
                p = -1;
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && in_ready[i]) p = i;
                end
                if (cur_src < 0) begin
                    e = rr_pick(last_m);
                    chk("rr_grant", 32'(p), 32'(e));
                    cur_src = e;
                end else begin
                    chk("pkt_lock", 32'(p), 32'(cur_src));
                end
                if (cur_src >= 0 && bp[cur_src] < nb[cur_src]) begin
                    eb = beat_e[cur_src][bp[cur_src]];
                    chk("beat_data", 32'(adder_data), 32'(beat_d[cur_src][bp[cur_src]]));
                    chk("beat_end", 32'(adder_end), 32'(eb));
                    pend_d.push_back(beat_d[cur_src][bp[cur_src]]);
                    pend_e.push_back(eb);
                    bp[cur_src]++;
                    if (eb) begin
                        for (int j = 0; j < pend_d.size(); j++) begin
                            rq_d.push_back(pend_d[j] ^ 8'hA5);
                            rq_e.push_back(pend_e[j]);
                            rq_s.push_back(cur_src);
                        end
                        pend_d.delete();
                        pend_e.delete();
                        last_m  = cur_src;
                        cur_src = -1;
                    end
                end
            end
            if (rsp_valid) begin
                s = rq_s[0];
                chk("rsp_route", 32'(out_valid), 32'(1 << s));
                chk("rsp_ready", 32'(rsp_ready), 32'(out_ready[s]));
                chk("rsp_beat", 32'({out_end, out_data}), 32'({rq_e[0], rq_d[0]}));
                if (rsp_ready) begin
                    void'(rq_d.pop_front());
                    void'(rq_e.pop_front());
                    void'(rq_s.pop_front());
                end
            end
            cyc++;
        end
        chk("rand_drain", 32'(all_done()), 32'h1);
        chk("rand_orphan", 32'(err_orphan), 32'h0);
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        do_reset();

        // Single requester on port 2, with one backpressure cycle.
        @(negedge clk);
        in_valid = 4'b0100; in_data[23:16] = 8'h01; in_end = '0; adder_ready = 1'b1; out_ready = '1;
        #1 chk("s_gap", 32'({in_ready, adder_valid}), 32'h0);
        @(negedge clk);
        #1 chk("s_beat1", 32'({in_ready, adder_valid, adder_end, adder_data}), 32'({4'b0100, 1'b1, 1'b0, 8'h01}));
        @(negedge clk);
        in_data[23:16] = 8'h02; adder_ready = 1'b0;
        #1 chk("s_bp", 32'({in_ready, adder_valid, adder_data}), 32'({4'b0000, 1'b1, 8'h02}));
        @(negedge clk);
        adder_ready = 1'b1;
        #1 chk("s_beat2", 32'({in_ready, adder_valid, adder_end, adder_data}), 32'({4'b0100, 1'b1, 1'b0, 8'h02}));
        @(negedge clk);
        in_data[23:16] = 8'h03; in_end[2] = 1'b1;
        #1 chk("s_beat3", 32'({in_ready, adder_valid, adder_end, adder_data}), 32'({4'b0100, 1'b1, 1'b1, 8'h03}));
        @(negedge clk);
        in_valid = '0; in_end = '0; in_data = '0;
        rsp_valid = 1'b1; rsp_data = 8'h06; rsp_end = 1'b1; out_ready = 4'b1011;
        #1 chk("s_rsp_stall", 32'({adder_valid, out_valid, rsp_ready}), 32'({1'b0, 4'b0100, 1'b0}));
        @(negedge clk);
        out_ready = '1;
        #1 chk("s_rsp", 32'({out_valid, rsp_ready, out_end, out_data}), 32'({4'b0100, 1'b1, 1'b1, 8'h06}));

        // Response with nothing outstanding.
        @(negedge clk);
        rsp_data = 8'h77;
        #1 chk("orph_route", 32'({out_valid, rsp_ready, err_orphan}), 32'h0);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1 chk("orph_set", 32'(err_orphan), 32'h1);
        repeat (3) @(negedge clk);
        #1 chk("orph_sticky", 32'(err_orphan), 32'h1);
        do_reset();

        // All ports contending with single-beat packets, responses held off until FIFO fills.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                in_valid = '1; in_end = '1; in_data = {8'h33, 8'h22, 8'h11, 8'h00};
                adder_ready = 1'b1; out_ready = '0;
            end
            #1;
            if (c < 8) chk("full_order", 32'(in_ready), (c % 2 == 1) ? 32'(1 << (c / 2)) : 32'h0);
            else       chk("full_wait", 32'({adder_valid, in_ready}), 32'h0);
        end
        @(negedge clk);
        rsp_valid = 1'b1; rsp_end = 1'b1; rsp_data = 8'h42; out_ready = '1;
        #1 chk("full_pop", 32'({out_valid, rsp_ready, adder_valid}), 32'({4'b0001, 1'b1, 1'b0}));
        @(negedge clk);
        rsp_valid = 1'b0; out_ready = '0;
        #1 chk("full_regrant_gap", 32'(adder_valid), 32'h0);
        @(negedge clk);
        #1 chk("full_regrant", 32'({in_ready, adder_valid, adder_data}), 32'({4'b0001, 1'b1, 8'h00}));
        do_reset();

        // Reset dropped in the middle of a 4-beat packet from port 1.
        @(negedge clk);
        in_valid = 4'b0010; in_data[15:8] = 8'hA1; in_end = '0; adder_ready = 1'b1;
        @(negedge clk);
        #1 chk("m_beat1", 32'({in_ready, adder_data}), 32'({4'b0010, 8'hA1}));
        @(negedge clk);
        in_data[15:8] = 8'hA2;
        #1 chk("m_beat2", 32'({in_ready, adder_data}), 32'({4'b0010, 8'hA2}));
        @(negedge clk);
        in_data[15:8] = 8'hA3; in_data[7:0] = 8'hB0; in_valid = 4'b0011;
        rsp_valid = 1'b1; rsp_data = 8'h55; out_ready = '1;
        reset = 1'b0;
        #1 chk("m_rst_outs", outs_vec(), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("m_flush", 32'({out_valid, rsp_ready, adder_valid}), 32'h0);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1 chk("m_prio", 32'({in_ready, adder_valid, adder_data}), 32'({4'b0001, 1'b1, 8'hB0}));
        clear_inputs();
        do_reset();

        // Randomized traffic rounds.
        for (int r = 0; r < 4; r++) begin
            run_random();
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
